// File: rtl/sc_regshifter_arbiter.sv
// rtl/sc_regshifter_arbiter.sv - two-requester round-robin arbiter and load/shift sequencer for SC_RegSHIFTER
module sc_regshifter_arbiter #(
    parameter int DATAWIDTH_BUS                  = 32,
    parameter int DATAWIDTH_SHIFTCOUNT           = 5,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
    input  logic                                      SC_RegSHIFTERARB_CLOCK_50,
    input  logic                                      SC_RegSHIFTERARB_Reset_InLow,
    input  logic                                      SC_RegSHIFTERARB_Req0_InLow,
    input  logic                                      SC_RegSHIFTERARB_Req1_InLow,
    input  logic                                      SC_RegSHIFTERARB_Dir0_In,
    input  logic                                      SC_RegSHIFTERARB_Dir1_In,
    input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_RegSHIFTERARB_Count0_In,
    input  logic [DATAWIDTH_SHIFTCOUNT-1:0]           SC_RegSHIFTERARB_Count1_In,
    input  logic [DATAWIDTH_BUS-1:0]                  SC_RegSHIFTERARB_Data0_In,
    input  logic [DATAWIDTH_BUS-1:0]                  SC_RegSHIFTERARB_Data1_In,
    output logic                                      SC_RegSHIFTERARB_Grant0_Out,
    output logic                                      SC_RegSHIFTERARB_Grant1_Out,
    output logic                                      SC_RegSHIFTERARB_Done0_Out,
    output logic                                      SC_RegSHIFTERARB_Done1_Out,
    output logic                                      SC_RegSHIFTERARB_Busy_Out,
    output logic                                      SC_RegSHIFTERARB_Load_OutLow,
    output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_RegSHIFTERARB_ShiftSelection_OutLow,
    output logic [DATAWIDTH_BUS-1:0]                  SC_RegSHIFTERARB_DataBUS_Out
);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_LOAD,
        STATE_SHIFT,
        STATE_DONE
    } state_t;

    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_HOLD  = '0;
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  = DATAWIDTH_REGSHIFTER_SELECTION'(1);
    localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT = DATAWIDTH_REGSHIFTER_SELECTION'(2);
    localparam logic [DATAWIDTH_SHIFTCOUNT-1:0]           COUNT_ZERO = '0;
    localparam logic [DATAWIDTH_SHIFTCOUNT-1:0]           COUNT_ONE  = DATAWIDTH_SHIFTCOUNT'(1);

    state_t                           stateReg, stateNext;
    logic                             ownerReg, ownerNext;
    logic                             lastServedReg, lastServedNext;
    logic                             dirReg, dirNext;
    logic [DATAWIDTH_SHIFTCOUNT-1:0]  countReg, countNext;
    logic [DATAWIDTH_SHIFTCOUNT-1:0]  counterReg, counterNext;
    logic                             bothRequesting;

    assign bothRequesting = !SC_RegSHIFTERARB_Req0_InLow && !SC_RegSHIFTERARB_Req1_InLow;

    always_ff @(posedge SC_RegSHIFTERARB_CLOCK_50 or negedge SC_RegSHIFTERARB_Reset_InLow) begin
        if (!SC_RegSHIFTERARB_Reset_InLow) begin
            stateReg      <= STATE_IDLE;
            ownerReg      <= 1'b0;
            lastServedReg <= 1'b1;
            dirReg        <= 1'b0;
            countReg      <= COUNT_ZERO;
            counterReg    <= COUNT_ZERO;
        end else begin
            stateReg      <= stateNext;
            ownerReg      <= ownerNext;
            lastServedReg <= lastServedNext;
            dirReg        <= dirNext;
            countReg      <= countNext;
            counterReg    <= counterNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        ownerNext      = ownerReg;
        lastServedNext = lastServedReg;
        dirNext        = dirReg;
        countNext      = countReg;
        counterNext    = counterReg;
        case (stateReg)
            STATE_IDLE: begin
                if (!SC_RegSHIFTERARB_Req0_InLow || !SC_RegSHIFTERARB_Req1_InLow) begin
                    // On a tie the requester not served last wins; otherwise Req0 high means Req1 is the one asking.
                    ownerNext = bothRequesting ? ~lastServedReg : SC_RegSHIFTERARB_Req0_InLow;
                    dirNext   = ownerNext ? SC_RegSHIFTERARB_Dir1_In : SC_RegSHIFTERARB_Dir0_In;
                    countNext = ownerNext ? SC_RegSHIFTERARB_Count1_In : SC_RegSHIFTERARB_Count0_In;
                    stateNext = STATE_LOAD;
                end
            end
            STATE_LOAD: begin
                counterNext = countReg;
                stateNext   = (countReg == COUNT_ZERO) ? STATE_DONE : STATE_SHIFT;
            end
            STATE_SHIFT: begin
                counterNext = counterReg - COUNT_ONE;
                if (counterReg == COUNT_ONE) begin
                    stateNext = STATE_DONE;
                end
            end
            STATE_DONE: begin
                lastServedNext = ownerReg;
                stateNext      = STATE_IDLE;
            end
            default: stateNext = STATE_IDLE;
        endcase
    end

    always_comb begin
        SC_RegSHIFTERARB_Grant0_Out            = 1'b0;
        SC_RegSHIFTERARB_Grant1_Out            = 1'b0;
        SC_RegSHIFTERARB_Done0_Out             = 1'b0;
        SC_RegSHIFTERARB_Done1_Out             = 1'b0;
        SC_RegSHIFTERARB_Busy_Out              = (stateReg != STATE_IDLE);
        SC_RegSHIFTERARB_Load_OutLow           = (stateReg != STATE_LOAD);
        SC_RegSHIFTERARB_ShiftSelection_OutLow = SEL_HOLD;
        SC_RegSHIFTERARB_DataBUS_Out           = '0;
        if (stateReg != STATE_IDLE) begin
            SC_RegSHIFTERARB_Grant0_Out  = !ownerReg;
            SC_RegSHIFTERARB_Grant1_Out  = ownerReg;
            SC_RegSHIFTERARB_DataBUS_Out = ownerReg ? SC_RegSHIFTERARB_Data1_In : SC_RegSHIFTERARB_Data0_In;
        end
        if (stateReg == STATE_SHIFT) begin
            SC_RegSHIFTERARB_ShiftSelection_OutLow = dirReg ? SEL_RIGHT : SEL_LEFT;
        end
        if (stateReg == STATE_DONE) begin
            SC_RegSHIFTERARB_Done0_Out = !ownerReg;
            SC_RegSHIFTERARB_Done1_Out = ownerReg;
        end
    end

endmodule

// File: tb/tb_sc_regshifter_arbiter.sv
// tb/tb_sc_regshifter_arbiter.sv - scoreboard bench for sc_regshifter_arbiter with a behavioural shifter model
module tb_sc_regshifter_arbiter;

    localparam int BW = 32;
    localparam int CW = 5;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rstN = 1'b1;
    logic          req0N = 1'b1, req1N = 1'b1;
    logic          dir0 = 1'b0, dir1 = 1'b0;
    logic [CW-1:0] count0 = '0, count1 = '0;
    logic [BW-1:0] data0 = '0, data1 = '0;
    logic          grant0, grant1, done0, done1, busy, loadN;
    logic [SW-1:0] sel;
    logic [BW-1:0] dataBus;

    always #5 clk = ~clk;

    sc_regshifter_arbiter #(
        .DATAWIDTH_BUS(BW),
        .DATAWIDTH_SHIFTCOUNT(CW),
        .DATAWIDTH_REGSHIFTER_SELECTION(SW)
    ) dut (
        .SC_RegSHIFTERARB_CLOCK_50(clk),
        .SC_RegSHIFTERARB_Reset_InLow(rstN),
        .SC_RegSHIFTERARB_Req0_InLow(req0N),
        .SC_RegSHIFTERARB_Req1_InLow(req1N),
        .SC_RegSHIFTERARB_Dir0_In(dir0),
        .SC_RegSHIFTERARB_Dir1_In(dir1),
        .SC_RegSHIFTERARB_Count0_In(count0),
        .SC_RegSHIFTERARB_Count1_In(count1),
        .SC_RegSHIFTERARB_Data0_In(data0),
        .SC_RegSHIFTERARB_Data1_In(data1),
        .SC_RegSHIFTERARB_Grant0_Out(grant0),
        .SC_RegSHIFTERARB_Grant1_Out(grant1),
        .SC_RegSHIFTERARB_Done0_Out(done0),
        .SC_RegSHIFTERARB_Done1_Out(done1),
        .SC_RegSHIFTERARB_Busy_Out(busy),
        .SC_RegSHIFTERARB_Load_OutLow(loadN),
        .SC_RegSHIFTERARB_ShiftSelection_OutLow(sel),
        .SC_RegSHIFTERARB_DataBUS_Out(dataBus)
    );

    typedef struct {
        logic          owner;
        logic [BW-1:0] data;
        logic          dir;
        int            n;
        logic [BW-1:0] result;
    } exp_t;

    exp_t          expQ[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic          lastServed = 1'b1;
    logic [BW-1:0] shifterModel = '0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input logic owner, input logic [BW-1:0] d, input logic dr, input int n);
        exp_t e;
        e.owner  = owner;
        e.data   = d;
        e.dir    = dr;
        e.n      = n;
        e.result = dr ? (d >> n) : (d << n);
        expQ.push_back(e);
    endtask

    // Downstream shifter: load when Load is low, else shift one place per selection code.
    always @(posedge clk) begin
        if (!loadN)           shifterModel <= dataBus;
        else if (sel == 2'b01) shifterModel <= shifterModel << 1;
        else if (sel == 2'b10) shifterModel <= shifterModel >> 1;
    end

    exp_t cur;
    bit   active = 1'b0;
    int   cyc = 0;

    always @(negedge clk) begin
        if (!rstN) begin
            active = 1'b0;
        end else begin
            check("grant_exclusive", {63'd0, grant0 & grant1}, 64'd0);
            if (active) begin
                cyc++;
                check("grant_owner_hold", {62'd0, grant1, grant0}, cur.owner ? 64'd2 : 64'd1);
                check("databus_owner", dataBus, cur.owner ? data1 : data0);
                check("busy_active", busy, 1);
                if (cyc <= cur.n) begin
                    check("shift_sel", sel, cur.dir ? 64'd2 : 64'd1);
                    check("shift_load", loadN, 1);
                    check("shift_no_done", {62'd0, done1, done0}, 0);
                end else begin
                    check("done_pulse", {62'd0, done1, done0}, cur.owner ? 64'd2 : 64'd1);
                    check("done_sel", sel, 0);
                    check("shifter_result", shifterModel, cur.result);
                    void'(expQ.pop_front());
                    active = 1'b0;
                end
            end else if (grant0 || grant1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_grant", {62'd0, grant1, grant0}, 0);
                end else begin
                    cur    = expQ[0];
                    active = 1'b1;
                    cyc    = 0;
                    check("grant_winner", {62'd0, grant1, grant0}, cur.owner ? 64'd2 : 64'd1);
                    check("load_low", loadN, 0);
                    check("load_data", dataBus, cur.data);
                    check("load_sel", sel, 0);
                    check("load_no_done", {62'd0, done1, done0}, 0);
                end
            end else begin
                check("idle_done", {62'd0, done1, done0}, 0);
                check("idle_outputs", {29'd0, busy, loadN, sel, dataBus}, {29'd0, 1'b0, 1'b1, 2'b00, 32'd0});
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        check({tag, "_grant"}, {62'd0, grant1, grant0}, 0);
        check({tag, "_done"}, {62'd0, done1, done0}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load"}, loadN, 1);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_databus"}, dataBus, 0);
    endtask

    task automatic waitDone(input logic who);
        int  seen = 0;
        bit  ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            #2;
            if (who ? grant1 : grant0) seen++;
            if (seen == 2) begin
                // Inputs changing after LOAD must not disturb the running operation.
                if (who) begin
                    dir1 = $urandom; count1 = CW'($urandom); data1 = $urandom;
                end else begin
                    dir0 = $urandom; count0 = CW'($urandom); data0 = $urandom;
                end
            end
            if (who ? done1 : done0) begin
                ok = 1'b1;
                if (who) req1N = 1'b1;
                else     req0N = 1'b1;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: requester %0d got no done, expected done within 100 cycles", who);
            req0N = 1'b1;
            req1N = 1'b1;
        end
    endtask

    task automatic runOp(input logic [1:0] mask,
                         input logic [BW-1:0] d0, input logic r0, input int c0,
                         input logic [BW-1:0] d1, input logic r1, input int c1);
        logic order[2];
        int   nOps;
        if (mask == 2'b11) begin
            order[0] = ~lastServed;
            order[1] = lastServed;
            nOps     = 2;
        end else begin
            order[0] = (mask == 2'b10);
            order[1] = 1'b0;
            nOps     = 1;
        end
        for (int i = 0; i < nOps; i++) begin
            if (order[i]) pushExp(1'b1, d1, r1, c1);
            else          pushExp(1'b0, d0, r0, c0);
        end
        lastServed = order[nOps-1];
        data0 = d0; dir0 = r0; count0 = CW'(c0);
        data1 = d1; dir1 = r1; count1 = CW'(c1);
        req0N = !mask[0];
        req1N = !mask[1];
        for (int i = 0; i < nOps; i++) waitDone(order[i]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  seen;
        // Reset held with both requests active.
        rstN  = 1'b0;
        req0N = 1'b0;
        req1N = 1'b0;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;

        // Tie after reset: 0, 1, then 0 again, 1 again.
        runOp(2'b11, $urandom, 1'b0, 3, $urandom, 1'b1, 2);
        runOp(2'b11, $urandom, 1'b1, 1, $urandom, 1'b0, 0);

        runOp(2'b01, 32'h0000_00F0, 1'b0, 4, 32'h0, 1'b0, 0);
        runOp(2'b10, 32'h0, 1'b0, 0, 32'hA5A5_A5A5, 1'b1, 0);
        runOp(2'b01, 32'h8000_0000, 1'b1, 31, 32'h0, 1'b0, 0);

        // Reset in the middle of a shift sequence.
        pushExp(1'b0, 32'h1234_5678, 1'b0, 5);
        data0 = 32'h1234_5678; dir0 = 1'b0; count0 = 5'd5;
        req0N = 1'b0;
        seen  = 0;
        for (int t = 0; t < 20 && seen < 3; t++) begin
            @(negedge clk);
            #2;
            if (grant0) seen++;
        end
        check("midshift_reached", seen, 3);
        rstN = 1'b0;
        #1;
        checkResetOutputs("reset_midshift");
        expQ.delete();
        lastServed = 1'b1;
        req0N = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        runOp(2'b01, 32'h0000_0003, 1'b0, 1, 32'h0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] mask;
            int         c0r, c1r;
            mask = 2'($urandom_range(1, 3));
            c0r  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 10);
            c1r  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 10);
            runOp(mask, $urandom, 1'($urandom), c0r, $urandom, 1'($urandom), c1r);
        end

        repeat (3) @(posedge clk);
        check("queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
